// File: rtl/pack_i64_stream.sv
// ---------------------------------------------------------------------------
// pack_i64_stream
//   Streaming signed-LEB128 encoder. One W-bit two's-complement value is
//   taken per input handshake and its minimal-length LEB128 byte sequence
//   is emitted one byte per cycle, with out_last marking the final byte.
//   Back-to-back values are accepted on the final-byte handshake, so there
//   is no bubble between encodings.
//
//   Optional feature macro: LEB128_UNSIGNED_EN
//     When defined, the is_unsigned port exists. It is sampled together with
//     in_data; when it is 1 the value is encoded as unsigned LEB128 (logical
//     shift, stop once the remainder is zero).
//
// Ports
//   clk          in   clock, all state on rising edge
//   rstn         in   asynchronous active-low reset
//   in_data      in   W   value to encode
//   in_valid     in   in_data valid
//   in_ready     out  block can accept a value
//   out_data     out  8   current LEB128 byte
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts out_data
//   out_last     out  out_data is the final byte
//   out_len      out  4   total byte count of the current encoding
//   is_unsigned  in   unsigned encoding select (LEB128_UNSIGNED_EN only)
// ---------------------------------------------------------------------------
module pack_i64_stream #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic [3:0]   out_len
`ifdef LEB128_UNSIGNED_EN
   ,
   input  logic         is_unsigned
`endif
);

   localparam int         MAXB   = (W + 6) / 7;
   localparam logic [3:0] MAXB_L = 4'(MAXB);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Remainder after emitting the low 7 bits of r.
   function automatic logic [W-1:0] shift7(input logic [W-1:0] r, input logic uns);
      logic [W-1:0] res;
      if (uns) begin
         res = r >> 3'd7;
      end else begin
         res = W'($signed(r) >>> 3'd7);
      end
      return res;
   endfunction

   // True when the byte taken from r is the last one of the encoding.
   function automatic logic is_final(input logic [W-1:0] r, input logic uns);
      logic [W-1:0] rn;
      logic         fin;
      rn = shift7(r, uns);
      if (uns) begin
         fin = (rn == '0);
      end else begin
         fin = ((rn == '0) && !r[6]) || ((rn == '1) && r[6]);
      end
      return fin;
   endfunction

   // Minimal byte count: walks the same stop rule as the byte emitter so the
   // length reported up front always matches the bytes that follow.
   function automatic logic [3:0] min_len(input logic [W-1:0] v, input logic uns);
      logic [W-1:0] r;
      logic         fin;
      logic [3:0]   n;
      r   = v;
      fin = 1'b0;
      n   = 4'd0;
      for (int i = 0; i < MAXB; i++) begin
         if (!fin) begin
            n   = n + 4'd1;
            fin = is_final(r, uns) || (n == MAXB_L);
            r   = shift7(r, uns);
         end else begin
            r = r;
         end
      end
      return n;
   endfunction

   state_t       state_r, state_n;
   logic [W-1:0] sh_r, sh_n;       // remainder still to be emitted
   logic [7:0]   data_r, data_n;
   logic         last_r, last_n;
   logic [3:0]   len_r, len_n;
   logic         valid_r, valid_n;
   logic [3:0]   cnt_r, cnt_n;     // 1-based index of the byte on out_data
   logic         uns_r, uns_n;

   logic         uns_in_s;
   logic         take_s;
   logic         adv_s;
   logic [W-1:0] src_s;
   logic         src_uns_s;
   logic [3:0]   cnt_src_s;
   logic         done_s;

`ifdef LEB128_UNSIGNED_EN
   assign uns_in_s = is_unsigned;
`else
   assign uns_in_s = 1'b0;
`endif

   assign in_ready  = (state_r == ST_IDLE) | (valid_r & out_ready & last_r);
   assign take_s    = in_valid & in_ready;
   assign adv_s     = valid_r & out_ready;

   // A fresh value is encoded straight from in_data; otherwise continue from
   // the stored remainder.
   assign src_s     = take_s ? in_data  : sh_r;
   assign src_uns_s = take_s ? uns_in_s : uns_r;
   assign cnt_src_s = take_s ? 4'd1     : (cnt_r + 4'd1);
   assign done_s    = is_final(src_s, src_uns_s) || (cnt_src_s == MAXB_L);

   // Next-state and next-output logic.
   always_comb begin
      state_n = state_r;
      sh_n    = sh_r;
      data_n  = data_r;
      last_n  = last_r;
      len_n   = len_r;
      valid_n = valid_r;
      cnt_n   = cnt_r;
      uns_n   = uns_r;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               state_n = ST_SEND;
               sh_n    = shift7(src_s, src_uns_s);
               data_n  = {~done_s, src_s[6:0]};
               last_n  = done_s;
               len_n   = min_len(in_data, uns_in_s);
               valid_n = 1'b1;
               cnt_n   = cnt_src_s;
               uns_n   = uns_in_s;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (adv_s && last_r) begin
               if (take_s) begin
                  state_n = ST_SEND;
                  sh_n    = shift7(src_s, src_uns_s);
                  data_n  = {~done_s, src_s[6:0]};
                  last_n  = done_s;
                  len_n   = min_len(in_data, uns_in_s);
                  valid_n = 1'b1;
                  cnt_n   = cnt_src_s;
                  uns_n   = uns_in_s;
               end else begin
                  state_n = ST_IDLE;
                  data_n  = 8'h00;
                  last_n  = 1'b0;
                  len_n   = 4'd0;
                  valid_n = 1'b0;
                  cnt_n   = 4'd0;
               end
            end else if (adv_s) begin
               sh_n   = shift7(src_s, src_uns_s);
               data_n = {~done_s, src_s[6:0]};
               last_n = done_s;
               cnt_n  = cnt_src_s;
            end else begin
               state_n = ST_SEND;
            end
         end
         default: begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            data_n  = 8'h00;
            len_n   = 4'd0;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         sh_r    <= '0;
         data_r  <= 8'h00;
         last_r  <= 1'b0;
         len_r   <= 4'd0;
         valid_r <= 1'b0;
         cnt_r   <= 4'd0;
         uns_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         sh_r    <= sh_n;
         data_r  <= data_n;
         last_r  <= last_n;
         len_r   <= len_n;
         valid_r <= valid_n;
         cnt_r   <= cnt_n;
         uns_r   <= uns_n;
      end
   end

   assign out_data  = data_r;
   assign out_last  = last_r;
   assign out_len   = len_r;
   assign out_valid = valid_r;

endmodule
